keypad_entry_decoder: RTL and testbench
=======================================

Name: keypad_entry_decoder

Overview:
Consumer end of the keypad encoder interface. Samples the encoder's key code/data-valid pair, debounces press and release, and assembles accepted digit keys into a BCD entry buffer. The enter key commits the buffer as a one-cycle-valid BCD number. Sits between the keypad scanner and the application logic (display, comparator, lock FSM).

Parameters:
NUM_DIGITS, 4, BCD digits held in the entry buffer (1..8)
DEBOUNCE_CYCLES, 16, consecutive clk samples of dav at one level needed to accept a press or release (>=1)
CNT_W, 5, width of the debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
dav  in  1  key data valid from encoder; level, high while a key is held
d  in  4  key code from encoder; 0-9 digit, 4'hF enter, 4'hA-4'hE ignored; may be Z/X while dav=0 and is never used then
key_strobe  out  1  one-cycle pulse per accepted key, digit or enter
digits  out  4*NUM_DIGITS  live entry buffer in BCD, newest digit in [3:0]
digit_count  out  4  number of digits entered, 0..NUM_DIGITS
value  out  4*NUM_DIGITS  last committed entry in BCD
value_valid  out  1  one-cycle pulse when value updates
overflow  out  1  sticky; a digit arrived with the buffer full

Behaviour:
- Reset (async assert, sync release): all outputs 0, debounce counter 0, FSM in REL_WAIT. A key held through reset must be released and re-pressed before it is accepted.
- FSM states: IDLE, PRESS_DB, HELD, REL_WAIT.
- IDLE: dav=1 -> PRESS_DB with counter=1. If DEBOUNCE_CYCLES=1, accept immediately and go to HELD.
- PRESS_DB: dav=1 increments the counter. When the counter reaches DEBOUNCE_CYCLES, accept and go to HELD. dav=0 -> IDLE with counter=0 and no key.
- Accept: d is sampled on the accepting edge. key_strobe is high in the following cycle, for exactly one cycle. Latency from the first dav=1 sample to key_strobe is DEBOUNCE_CYCLES cycles.
- HELD: dav=0 -> REL_WAIT with counter=1. A held key never repeats.
- REL_WAIT: dav=0 increments the counter. When the counter reaches DEBOUNCE_CYCLES -> IDLE. dav=1 -> HELD with counter=0.
- Accepted digit (0-9):
  - If digit_count<NUM_DIGITS: digits <= {digits[4*NUM_DIGITS-5:0], d}, digit_count+1.
  - Otherwise the buffer is unchanged and overflow is set.
  - Updates land in the same cycle as key_strobe.
- Accepted enter (4'hF):
  - With digit_count>0: value <= digits; value_valid pulses together with key_strobe; digits and digit_count clear to 0; overflow clears.
  - With digit_count=0: key_strobe still pulses, but no value_valid and value is unchanged.
- Accepted 4'hA-4'hE: key_strobe pulses, no other state changes.
- value holds between commits. value_valid is never high for two consecutive cycles.
- d changing while the FSM is in HELD or REL_WAIT is ignored.

Test Plan:
(All with DEBOUNCE_CYCLES=3, NUM_DIGITS=4.)
- Reset release with dav=0, hold dav=0 for 3 cycles -> FSM reaches IDLE; all outputs remain 0.
- Digit entry: press d=1, then 2, then 3, each with dav high 5 cycles and low 5 cycles; then press d=F -> three key_strobe pulses; digits goes 0x0001, 0x0012, 0x0123; then value=0x0123 with a single value_valid pulse; digits=0, digit_count=0.
- Bounce: dav high 2 cycles, low 1, high 5 with d=7 -> exactly one key_strobe, 3 cycles after the final rise; digits=0x0007.
- Overflow: enter 9,8,7,6,5 -> digits=0x9876, digit_count=4, overflow=1 after the 5th key. Then enter -> value=0x9876, overflow=0.
- Empty enter and ignored codes: d=F with no digits, then d=B -> two key_strobe pulses, no value_valid; value and digits unchanged.
- Reset mid-operation: assert rst while dav=1 in HELD with digits=0x0045 -> all outputs 0 immediately. After release, keep dav=1 -> no key_strobe until dav has been low for 3 cycles and then high for 3 cycles.

Source files
------------

// File: rtl/keypad_entry_decoder.sv
// rtl/keypad_entry_decoder.sv - debounced keypad consumer assembling BCD entries
// Debounces the encoder dav level, accepts one key per press and commits digits on enter.
module keypad_entry_decoder #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dav,
  input  logic [3:0]              d,
  output logic                    key_strobe,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic                    overflow
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CNT_W:0] DB_LIMIT = (CNT_W+1)'(DEBOUNCE_CYCLES);
  localparam logic [3:0] MAX_COUNT = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             accept;

  logic             key_strobe_q, key_strobe_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [3:0]       count_q, count_d;
  logic [DW-1:0]    value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= REL_WAIT;
      cnt_q         <= '0;
      key_strobe_q  <= 1'b0;
      digits_q      <= '0;
      count_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_strobe_q  <= key_strobe_d;
      digits_q      <= digits_d;
      count_q       <= count_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  // Debounce FSM: the counter tracks consecutive samples at the level being qualified.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    case (state_q)
      IDLE: begin
        if (dav) begin
          if (DB_LIMIT == 1) begin
            accept  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!dav) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LIMIT) begin
          accept  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      HELD: begin
        if (!dav) begin
          if (DB_LIMIT == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = REL_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      REL_WAIT: begin
        if (dav) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LIMIT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_d = REL_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Entry buffer; d is only looked at on the accepting edge.
  always_comb begin
    key_strobe_d  = accept;
    digits_d      = digits_q;
    count_d       = count_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    overflow_d    = overflow_q;
    if (accept) begin
      if (d <= 4'd9) begin
        if (count_q < MAX_COUNT) begin
          digits_d = (digits_q << 4) | DW'(d);
          count_d  = count_q + 4'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (d == 4'hF && count_q != 4'd0) begin
        value_d       = digits_q;
        value_valid_d = 1'b1;
        digits_d      = '0;
        count_d       = '0;
        overflow_d    = 1'b0;
      end
    end
  end

  assign key_strobe  = key_strobe_q;
  assign digits      = digits_q;
  assign digit_count = count_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// tb/tb_keypad_entry_decoder.sv - directed self-checking bench for keypad_entry_decoder
module tb_keypad_entry_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dav = 1'b0;
  logic [3:0]  d = 4'h0;
  logic        key_strobe;
  logic [15:0] digits;
  logic [3:0]  digit_count;
  logic [15:0] value;
  logic        value_valid;
  logic        overflow;

  int asserts = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int vv_cnt = 0;
  int vv_double = 0;
  logic vv_prev = 1'b0;

  keypad_entry_decoder #(
    .NUM_DIGITS(4),
    .DEBOUNCE_CYCLES(3),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dav(dav),
    .d(d),
    .key_strobe(key_strobe),
    .digits(digits),
    .digit_count(digit_count),
    .value(value),
    .value_valid(value_valid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_strobe) begin
        strobe_cnt++;
        strobe_cyc = cyc;
      end
      if (value_valid) vv_cnt++;
      if (value_valid && vv_prev) vv_double++;
      vv_prev = value_valid;
    end else begin
      vv_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hi, input int lo);
    d = k;
    dav = 1'b1;
    repeat (hi) step();
    dav = 1'b0;
    d = 4'bxxxx;
    repeat (lo) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    asserts++;
    if ({key_strobe, digits, digit_count, value, value_valid, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_hold: outputs=%h expected 0", {key_strobe, digits, digit_count, value, value_valid, overflow});
    end
    rst = 1'b0;
    repeat (3) step();
    asserts++;
    if ({key_strobe, digits, digit_count, value, value_valid, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_release: outputs=%h expected 0", {key_strobe, digits, digit_count, value, value_valid, overflow});
    end
    asserts++;
    if (strobe_cnt !== 0) begin
      failures++;
      $display("FAIL reset_strobes: got %0d expected 0", strobe_cnt);
    end
  endtask

  task automatic test_digit_entry();
    int s0, v0;
    logic [15:0] exp_dig [3];
    logic [3:0]  keys [3];
    exp_dig = '{16'h0001, 16'h0012, 16'h0123};
    keys = '{4'h1, 4'h2, 4'h3};
    s0 = strobe_cnt;
    v0 = vv_cnt;
    for (int i = 0; i < 3; i++) begin
      press(keys[i], 5, 5);
      asserts++;
      if (digits !== exp_dig[i] || digit_count !== 4'(i + 1)) begin
        failures++;
        $display("FAIL entry_digit%0d: digits=%h count=%0d expected %h count=%0d", i, digits, digit_count, exp_dig[i], i + 1);
      end
    end
    press(4'hF, 5, 5);
    asserts++;
    if (strobe_cnt - s0 !== 4) begin
      failures++;
      $display("FAIL entry_strobes: got %0d expected 4", strobe_cnt - s0);
    end
    asserts++;
    if (value !== 16'h0123 || vv_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL entry_commit: value=%h vv=%0d expected 0123 vv=1", value, vv_cnt - v0);
    end
    asserts++;
    if (digits !== 16'h0 || digit_count !== 4'd0) begin
      failures++;
      $display("FAIL entry_clear: digits=%h count=%0d expected 0 0", digits, digit_count);
    end
  endtask

  task automatic test_bounce();
    int s0, rise;
    s0 = strobe_cnt;
    d = 4'h7;
    dav = 1'b1;
    repeat (2) step();
    dav = 1'b0;
    step();
    dav = 1'b1;
    rise = cyc;
    repeat (5) step();
    dav = 1'b0;
    d = 4'bxxxx;
    repeat (5) step();
    asserts++;
    if (strobe_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL bounce_strobes: got %0d expected 1", strobe_cnt - s0);
    end
    asserts++;
    if (strobe_cyc - rise !== 3) begin
      failures++;
      $display("FAIL bounce_latency: got %0d expected 3", strobe_cyc - rise);
    end
    asserts++;
    if (digits !== 16'h0007 || digit_count !== 4'd1) begin
      failures++;
      $display("FAIL bounce_digits: digits=%h count=%0d expected 0007 1", digits, digit_count);
    end
    press(4'hF, 4, 4);
    asserts++;
    if (value !== 16'h0007 || digits !== 16'h0) begin
      failures++;
      $display("FAIL bounce_commit: value=%h digits=%h expected 0007 0000", value, digits);
    end
  endtask

  task automatic test_overflow();
    int v0;
    press(4'h9, 4, 4);
    press(4'h8, 4, 4);
    press(4'h7, 4, 4);
    press(4'h6, 4, 4);
    asserts++;
    if (digits !== 16'h9876 || digit_count !== 4'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full: digits=%h count=%0d ovf=%b expected 9876 4 0", digits, digit_count, overflow);
    end
    press(4'h5, 4, 4);
    asserts++;
    if (digits !== 16'h9876 || digit_count !== 4'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: digits=%h count=%0d ovf=%b expected 9876 4 1", digits, digit_count, overflow);
    end
    v0 = vv_cnt;
    press(4'hF, 4, 4);
    asserts++;
    if (value !== 16'h9876 || overflow !== 1'b0 || vv_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL ovf_commit: value=%h ovf=%b vv=%0d expected 9876 0 1", value, overflow, vv_cnt - v0);
    end
  endtask

  task automatic test_empty_and_ignored();
    int s0, v0;
    s0 = strobe_cnt;
    v0 = vv_cnt;
    press(4'hF, 4, 4);
    press(4'hB, 4, 4);
    asserts++;
    if (strobe_cnt - s0 !== 2 || vv_cnt - v0 !== 0) begin
      failures++;
      $display("FAIL empty_pulses: strobes=%0d vv=%0d expected 2 0", strobe_cnt - s0, vv_cnt - v0);
    end
    asserts++;
    if (value !== 16'h9876 || digits !== 16'h0 || digit_count !== 4'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL empty_state: value=%h digits=%h count=%0d ovf=%b expected 9876 0000 0 0", value, digits, digit_count, overflow);
    end
  endtask

  task automatic test_reset_midop();
    int s0;
    press(4'h4, 4, 4);
    d = 4'h5;
    dav = 1'b1;
    repeat (4) step();
    asserts++;
    if (digits !== 16'h0045) begin
      failures++;
      $display("FAIL midop_setup: digits=%h expected 0045", digits);
    end
    rst = 1'b1;
    #1;
    asserts++;
    if ({key_strobe, digits, digit_count, value, value_valid, overflow} !== '0) begin
      failures++;
      $display("FAIL midop_async: outputs=%h expected 0", {key_strobe, digits, digit_count, value, value_valid, overflow});
    end
    step();
    rst = 1'b0;
    s0 = strobe_cnt;
    repeat (6) step();
    asserts++;
    if (strobe_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL midop_held: strobes=%0d expected 0", strobe_cnt - s0);
    end
    dav = 1'b0;
    repeat (3) step();
    d = 4'h2;
    dav = 1'b1;
    repeat (2) step();
    asserts++;
    if (strobe_cnt - s0 !== 0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL midop_early: strobes=%0d ks=%b expected 0 0", strobe_cnt - s0, key_strobe);
    end
    step();
    asserts++;
    if (key_strobe !== 1'b1 || digits !== 16'h0002) begin
      failures++;
      $display("FAIL midop_accept: ks=%b digits=%h expected 1 0002", key_strobe, digits);
    end
    dav = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_bounce();
    test_overflow();
    test_empty_and_ignored();
    test_reset_midop();
    asserts++;
    if (vv_double !== 0) begin
      failures++;
      $display("FAIL vv_consecutive: got %0d expected 0", vv_double);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
